scoreboard_ctrl: RTL and testbench

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

---
 rtl/scoreboard_ctrl.sv | 98 +++++++++
 tb/tb_scoreboard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: dice-game scoreboard that runs each commit through an external score calculator and keeps per-category scores, sums and bonus
module scoreboard_ctrl #(
  parameter int NUM_CAT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [14:0]        dice_in,
  input  logic               commit_valid,
  input  logic [3:0]         commit_cat,
  output logic               commit_ready,
  input  logic               new_game,
  output logic [14:0]        calc_dice,
  output logic [3:0]         calc_cat_sel,
  input  logic [7:0]         calc_score,
  output logic               resp_valid,
  output logic               resp_accepted,
  output logic [7:0]         resp_score,
  output logic [NUM_CAT-1:0] used_mask,
  output logic [6:0]         upper_sum,
  output logic               bonus,
  output logic [9:0]         total_score,
  output logic               game_over,
  input  logic [3:0]         rd_cat,
  output logic [7:0]         rd_score
);
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;
  state_t      state;
  logic [7:0]  scores [16];
  logic [7:0]  score_q;
  logic        acc_q;
  logic [7:0]  lower_sum;
  logic [15:0] mask16;
  logic        bad_dice;
  logic        reject;
  assign mask16       = 16'(used_mask);
  assign commit_ready = state == IDLE && !new_game;
  assign bonus        = upper_sum >= 7'd63;
  assign game_over    = &used_mask;
  assign total_score  = 10'(upper_sum) + 10'(lower_sum) + (bonus ? 10'd35 : 10'd0);
  assign reject       = {1'b0, commit_cat} >= 5'(NUM_CAT) || mask16[commit_cat] || game_over || bad_dice;
  always_comb begin
    bad_dice = 1'b0;
    for (int k = 0; k < 5; k++)
      bad_dice |= dice_in[3*k +: 3] == 3'd0 || dice_in[3*k +: 3] == 3'd7;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      for (int i = 0; i < 16; i++) scores[i] <= '0;
      score_q       <= '0;
      acc_q         <= 1'b0;
      used_mask     <= '0;
      upper_sum     <= '0;
      lower_sum     <= '0;
      resp_valid    <= 1'b0;
      resp_accepted <= 1'b0;
      resp_score    <= '0;
      rd_score      <= '0;
      calc_dice     <= '0;
      calc_cat_sel  <= '0;
    end else begin
      resp_valid <= state == RESP;
      rd_score   <= mask16[rd_cat] ? scores[rd_cat] : 8'd0;
      if (state == RESP) begin
        resp_accepted <= acc_q;
        resp_score    <= acc_q ? score_q : 8'd0;
      end
      case (state)
        IDLE:
          if (new_game) begin
            for (int i = 0; i < 16; i++) scores[i] <= '0;
            used_mask <= '0;
            upper_sum <= '0;
            lower_sum <= '0;
          end else if (commit_valid) begin
            acc_q <= !reject;
            state <= reject ? RESP : LOOKUP;
            if (!reject) begin
              calc_dice    <= dice_in;
              calc_cat_sel <= commit_cat;
            end
          end
        LOOKUP: begin
          score_q <= calc_score;
          state   <= UPDATE;
        end
        UPDATE: begin
          scores[calc_cat_sel]    <= score_q;
          used_mask[calc_cat_sel] <= 1'b1;
          if (calc_cat_sel < 4'd6) upper_sum <= upper_sum + 7'(score_q);
          else lower_sum <= lower_sum + score_q;
          state <= RESP;
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: scoreboard bench with a category-level game model and a decoupled response monitor
module tb_scoreboard_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic [14:0] dice_in = '0;
  logic        commit_valid = 0;
  logic [3:0]  commit_cat = '0;
  logic        commit_ready;
  logic        new_game = 0;
  logic [14:0] calc_dice;
  logic [3:0]  calc_cat_sel;
  logic [7:0]  calc_score;
  logic        resp_valid;
  logic        resp_accepted;
  logic [7:0]  resp_score;
  logic [11:0] used_mask;
  logic [6:0]  upper_sum;
  logic        bonus;
  logic [9:0]  total_score;
  logic        game_over;
  logic [3:0]  rd_cat = '0;
  logic [7:0]  rd_score;
  int passes = 0;
  int checks = 0;
  int cyc = 0;
  int bias [16];
  bit used [12];
  int sc [12];
  typedef struct {bit acc; int score; int at; int mask; int upper; int total; bit go;} exp_t;
  exp_t q [$];
  exp_t mon_e;
  scoreboard_ctrl dut (
    .clk(clk), .rst(rst), .dice_in(dice_in), .commit_valid(commit_valid),
    .commit_cat(commit_cat), .commit_ready(commit_ready), .new_game(new_game),
    .calc_dice(calc_dice), .calc_cat_sel(calc_cat_sel), .calc_score(calc_score),
    .resp_valid(resp_valid), .resp_accepted(resp_accepted), .resp_score(resp_score),
    .used_mask(used_mask), .upper_sum(upper_sum), .bonus(bonus),
    .total_score(total_score), .game_over(game_over), .rd_cat(rd_cat), .rd_score(rd_score)
  );
  assign calc_score = 8'(bias[calc_cat_sel] + int'(calc_dice[2:0]) + int'(calc_dice[14:12]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int m_upper();
    int s = 0;
    for (int c = 0; c < 6; c++) s += sc[c];
    return s;
  endfunction
  function automatic int m_total();
    int u = m_upper();
    int l = 0;
    for (int c = 6; c < 12; c++) l += sc[c];
    return u + l + (u >= 63 ? 35 : 0);
  endfunction
  function automatic int m_mask();
    int m = 0;
    for (int c = 0; c < 12; c++) if (used[c]) m += 1 << c;
    return m;
  endfunction
  function automatic bit m_all();
    return m_mask() == 12'hfff;
  endfunction
  function automatic void m_clear();
    for (int c = 0; c < 12; c++) begin
      used[c] = 0;
      sc[c] = 0;
    end
  endfunction
  function automatic logic [14:0] pack(int d1, int d2, int d3, int d4, int d5);
    return {3'(d5), 3'(d4), 3'(d3), 3'(d2), 3'(d1)};
  endfunction
  function automatic logic [14:0] rand_dice(bit allow_bad);
    logic [14:0] d;
    int k;
    for (int i = 0; i < 5; i++) d[3*i +: 3] = 3'($urandom_range(1, 6));
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      k = $urandom_range(0, 4);
      d[3*k +: 3] = $urandom_range(0, 1) == 1 ? 3'd0 : 3'd7;
    end
    return d;
  endfunction
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("resp_latency", cyc, mon_e.at);
        chk("resp_accepted", int'(resp_accepted), int'(mon_e.acc));
        chk("resp_score", int'(resp_score), mon_e.score);
        chk("used_mask", int'(used_mask), mon_e.mask);
        chk("upper_sum", int'(upper_sum), mon_e.upper);
        chk("bonus", int'(bonus), mon_e.upper >= 63 ? 1 : 0);
        chk("total_score", int'(total_score), mon_e.total);
        chk("game_over", int'(game_over), int'(mon_e.go));
      end
    end
  end
  task automatic commit(int cat, logic [14:0] d, bit track = 1);
    exp_t e;
    bit bad = 0;
    int g = 0;
    @(negedge clk);
    while (!commit_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!commit_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < 5; k++) if (d[3*k +: 3] == 3'd0 || d[3*k +: 3] == 3'd7) bad = 1;
    e.acc = !(bad || m_all() || cat >= 12);
    if (e.acc && used[cat]) e.acc = 0;
    e.score = e.acc ? (bias[cat] + int'(d[2:0]) + int'(d[14:12])) % 256 : 0;
    if (e.acc) begin
      used[cat] = 1;
      sc[cat] = e.score;
    end
    e.at = cyc + (e.acc ? 4 : 2);
    e.mask = m_mask();
    e.upper = m_upper();
    e.total = m_total();
    e.go = m_all();
    if (track) q.push_back(e);
    commit_valid = 1;
    commit_cat = 4'(cat);
    dice_in = d;
    @(posedge clk);
    #1;
    commit_valid = 0;
    dice_in = 15'($urandom);
  endtask
  task automatic drain();
    int g = 0;
    @(negedge clk);
    while ((q.size() != 0 || !commit_ready) && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic do_new_game(bit with_commit);
    drain();
    new_game = 1;
    if (with_commit) begin
      commit_valid = 1;
      commit_cat = 4'd0;
      dice_in = pack(3, 3, 3, 3, 3);
    end
    #1 chk("ready_during_new_game", int'(commit_ready), 0);
    @(posedge clk);
    #1;
    new_game = 0;
    commit_valid = 0;
    m_clear();
    @(negedge clk);
    chk("ng_used_mask", int'(used_mask), 0);
    chk("ng_total", int'(total_score), 0);
    chk("ng_game_over", int'(game_over), 0);
  endtask
  initial begin
    int c;
    m_clear();
    for (int i = 0; i < 16; i++) bias[i] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_ready", int'(commit_ready), 1);
    chk("rst_used_mask", int'(used_mask), 0);
    chk("rst_total", int'(total_score), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    bias[8] = 4;
    commit(8, pack(1, 1, 1, 2, 2));
    chk("lookup_cat_sel", int'(calc_cat_sel), 8);
    chk("lookup_dice", int'(calc_dice), int'(pack(1, 1, 1, 2, 2)));
    drain();
    commit(8, pack(1, 1, 1, 2, 2));
    commit(12, pack(2, 2, 2, 2, 2));
    commit(3, pack(1, 1, 0, 2, 2));
    commit(4, pack(7, 1, 1, 2, 2));
    drain();
    chk("reject_mask", int'(used_mask), 'h100);
    chk("reject_total", int'(total_score), 7);
    do_new_game(0);
    bias[0] = 1; bias[1] = 4; bias[2] = 7; bias[3] = 10; bias[4] = 13; bias[5] = 16;
    for (int i = 0; i < 6; i++) commit(i, pack(1, 1, 1, 1, 1));
    drain();
    chk("bonus_upper", int'(upper_sum), 63);
    chk("bonus_flag", int'(bonus), 1);
    chk("bonus_total", int'(total_score), 98);
    rd_cat = 4'd2;
    @(negedge clk) chk("rd_cat2", int'(rd_score), 9);
    rd_cat = 4'd9;
    @(negedge clk) chk("rd_unused", int'(rd_score), 0);
    rd_cat = 4'd12;
    @(negedge clk) chk("rd_oob", int'(rd_score), 0);
    do_new_game(1);
    commit(7, pack(4, 4, 4, 4, 4), 0);
    chk("inflight_cat_sel", int'(calc_cat_sel), 7);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    m_clear();
    #1;
    chk("midrst_ready", int'(commit_ready), 1);
    chk("midrst_used_mask", int'(used_mask), 0);
    repeat (8) @(negedge clk);
    chk("midrst_resp_valid", int'(resp_valid), 0);
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) bias[i] = i < 6 ? $urandom_range(0, 5) : $urandom_range(0, 18);
      repeat (50) commit($urandom_range(0, 13), rand_dice(1));
      for (int i = 0; i < 12; i++) if (!used[i]) commit(i, rand_dice(0));
      drain();
      chk("full_game_over", int'(game_over), 1);
      commit($urandom_range(0, 11), rand_dice(0));
      drain();
      c = $urandom_range(0, 11);
      rd_cat = 4'(c);
      @(negedge clk) chk("rd_random", int'(rd_score), sc[c]);
      do_new_game(g == 1);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
